// File: rtl/led_fade_pwm_if.sv
// ---------------------------------------------------------------------------
// led_fade_pwm_if
// Purpose : groups the pattern/brightness inputs and the PWM drive outputs of
//           the LED fader so that one handle connects the fader to its
//           upstream pattern generator and the board pins.
// Signals : led_in[7:0]    target pattern, bit i = 1 means LED i on
//           max_level[7:0] global brightness cap for "on" targets
//           fade_en        1 = ramp one step per tick, 0 = jump to target
//           led_out[7:0]   PWM drive to the LED pins, active high
//           period_start   one-cycle pulse in the first cycle of a PWM period
//           busy           1 while any channel level differs from its target
// Modports: master - pattern source side (drives targets, observes outputs)
//           slave  - the fader itself
// ---------------------------------------------------------------------------
interface led_fade_pwm_if;
    logic [7:0] led_in;
    logic [7:0] max_level;
    logic       fade_en;
    logic [7:0] led_out;
    logic       period_start;
    logic       busy;

    modport master (
        output led_in,
        output max_level,
        output fade_en,
        input  led_out,
        input  period_start,
        input  busy
    );

    modport slave (
        input  led_in,
        input  max_level,
        input  fade_en,
        output led_out,
        output period_start,
        output busy
    );
endinterface

// File: rtl/led_fade_pwm.sv
// ---------------------------------------------------------------------------
// led_fade_pwm
// Purpose : drives 8 LEDs with PWM, ramping each channel's brightness toward
//           its target (on = max_level, off = 0) so an on/off pattern turns
//           into a smooth fading chaser. Duty only changes at PWM period
//           boundaries, so the outputs never glitch mid-period.
// Params  : PRESCALE - sys_clk cycles per PWM counter step (>= 1)
//           FADE_DIV - PWM periods per brightness step (>= 1)
// Ports   : sys_clk  - system clock
//           sys_nrst - asynchronous active-low reset
//           bus      - led_fade_pwm_if.slave (led_in, max_level, fade_en in;
//                      led_out, period_start, busy out)
// ---------------------------------------------------------------------------
module led_fade_pwm #(
    parameter int PRESCALE = 4,
    parameter int FADE_DIV = 48
) (
    input  logic           sys_clk,
    input  logic           sys_nrst,
    led_fade_pwm_if.slave  bus
);
    // Counter widths; a divide-by-one counter still needs one (constant) bit.
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic [PRE_W-1:0]  r_pre_cnt;
    logic [7:0]        r_pwm_cnt;
    logic [FADE_W-1:0] r_fade_cnt;
    logic [7:0][7:0]   r_level;
    logic [7:0][7:0]   r_shadow;
    logic [7:0]        r_led_out;
    logic              r_period_start;
    logic              r_busy;

    logic              w_pre_wrap;
    logic              w_fade_wrap;
    logic              w_eop;
    logic              w_tick;
    logic [7:0][7:0]   w_tgt;
    logic [7:0][7:0]   w_step;
    logic [7:0][7:0]   w_level_next;
    logic [7:0]        w_diff;
    logic [7:0]        w_led_next;

    assign w_pre_wrap  = (r_pre_cnt == PRE_W'(PRESCALE - 1));
    assign w_fade_wrap = (r_fade_cnt == FADE_W'(FADE_DIV - 1));
    assign w_eop       = w_pre_wrap && (r_pwm_cnt == 8'hFF);
    assign w_tick      = w_eop && w_fade_wrap;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch
            assign w_tgt[gi]  = bus.led_in[gi] ? bus.max_level : 8'd0;
            assign w_diff[gi] = (r_level[gi] != w_tgt[gi]);

            // A step is only taken toward a strictly larger/smaller target,
            // so the level can never wrap past 0 or 255.
            assign w_step[gi] = (r_level[gi] < w_tgt[gi]) ? r_level[gi] + 8'd1 :
                                (r_level[gi] > w_tgt[gi]) ? r_level[gi] - 8'd1 :
                                                            r_level[gi];
            assign w_level_next[gi] = bus.fade_en ? w_step[gi] : w_tgt[gi];

            // 255 must be fully on; the plain compare would leave one low cycle.
            assign w_led_next[gi] = (r_shadow[gi] == 8'hFF) ||
                                    (r_pwm_cnt < r_shadow[gi]);
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            r_pre_cnt      <= '0;
            r_pwm_cnt      <= '0;
            r_fade_cnt     <= '0;
            r_level        <= '0;
            r_shadow       <= '0;
            r_led_out      <= '0;
            r_period_start <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_pre_cnt <= w_pre_wrap ? '0 : r_pre_cnt + PRE_W'(1);
            if (w_pre_wrap)
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (w_eop) begin
                r_fade_cnt <= w_fade_wrap ? '0 : r_fade_cnt + FADE_W'(1);
                // Shadow takes the pre-update level on a tick, so a new level
                // is displayed one period after it is computed.
                r_shadow   <= r_level;
            end
            if (w_tick)
                r_level <= w_level_next;
            r_led_out      <= w_led_next;
            r_period_start <= w_eop;
            r_busy         <= |w_diff;
        end
    end

    assign bus.led_out      = r_led_out;
    assign bus.period_start = r_period_start;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_led_fade_pwm.sv
// ---------------------------------------------------------------------------
// tb_led_fade_pwm
// Purpose : self-checking bench for led_fade_pwm. Two instances run side by
//           side on the same stimulus: one with PRESCALE=1/FADE_DIV=1 and one
//           with PRESCALE=4/FADE_DIV=2. A behavioural model derives the PWM
//           position, period ends and ramp ticks from the cycle count since
//           reset and keeps per-channel brightness in plain arrays.
// ---------------------------------------------------------------------------
module tb_led_fade_pwm;
    logic sys_clk  = 1'b0;
    logic sys_nrst = 1'b1;

    always #5 sys_clk = ~sys_clk;

    led_fade_pwm_if if_a ();
    led_fade_pwm_if if_b ();

    led_fade_pwm #(.PRESCALE(1), .FADE_DIV(1)) dut_a (
        .sys_clk  (sys_clk),
        .sys_nrst (sys_nrst),
        .bus      (if_a.slave)
    );

    led_fade_pwm #(.PRESCALE(4), .FADE_DIV(2)) dut_b (
        .sys_clk  (sys_clk),
        .sys_nrst (sys_nrst),
        .bus      (if_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Current stimulus (shared by both instances)
    logic [7:0] t_led_in;
    logic [7:0] t_max;
    logic       t_fade_en;

    // Reference model state, index 0 = dut_a, 1 = dut_b
    int unsigned m_p    [2] = '{1, 4};
    int unsigned m_f    [2] = '{1, 2};
    int unsigned m_n    [2];
    int          m_last_ps [2];
    logic [7:0]  m_level  [2][8];
    logic [7:0]  m_shadow [2][8];

    task automatic set_in(input logic [7:0] l, input logic [7:0] m, input logic f);
        t_led_in = l; t_max = m; t_fade_en = f;
        if_a.led_in = l; if_a.max_level = m; if_a.fade_en = f;
        if_b.led_in = l; if_b.max_level = m; if_b.fade_en = f;
        $display("stim led_in=%02h max_level=%0d fade_en=%0d", l, m, f);
    endtask

    function automatic logic [7:0] target(input int i);
        return t_led_in[i] ? t_max : 8'd0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_n[d] = 0;
            m_last_ps[d] = -1;
            for (int i = 0; i < 8; i++) begin
                m_level[d][i]  = 8'd0;
                m_shadow[d][i] = 8'd0;
            end
        end
    endtask

    // Called #1 after a clock edge: the DUT has just acted on model state m_n.
    task automatic model_step(input int d);
        logic [7:0]  obs_led, exp_led;
        logic        obs_ps, obs_busy, exp_busy;
        int unsigned per, phase, pwm;
        bit          eop, tick;
        string       nm;
        nm = (d == 0) ? "a" : "b";
        if (d == 0) begin
            obs_led = if_a.led_out; obs_ps = if_a.period_start; obs_busy = if_a.busy;
        end else begin
            obs_led = if_b.led_out; obs_ps = if_b.period_start; obs_busy = if_b.busy;
        end
        per   = 256 * m_p[d];
        phase = m_n[d] % per;
        pwm   = phase / m_p[d];
        eop   = (phase == per - 1);
        tick  = eop && (((m_n[d] / per) % m_f[d]) == m_f[d] - 1);

        exp_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_led[i] = (m_shadow[d][i] == 8'd255) || (pwm < m_shadow[d][i]);
            if (m_level[d][i] != target(i)) exp_busy = 1'b1;
        end
        check($sformatf("%s_led_out", nm), obs_led, exp_led);
        check($sformatf("%s_period_start", nm), obs_ps, eop);
        check($sformatf("%s_busy", nm), obs_busy, exp_busy);

        if (obs_ps) begin
            if (m_last_ps[d] >= 0)
                check($sformatf("%s_period_interval", nm), m_n[d] - m_last_ps[d], per);
            m_last_ps[d] = m_n[d];
        end

        if (eop)
            for (int i = 0; i < 8; i++) m_shadow[d][i] = m_level[d][i];
        if (tick) begin
            for (int i = 0; i < 8; i++) begin
                if (!t_fade_en)                         m_level[d][i] = target(i);
                else if (m_level[d][i] < target(i))     m_level[d][i] = m_level[d][i] + 8'd1;
                else if (m_level[d][i] > target(i))     m_level[d][i] = m_level[d][i] - 8'd1;
            end
            $display("tick dut_%s cycle=%0d level0=%0d level7=%0d", nm, m_n[d],
                     m_level[d][0], m_level[d][7]);
        end
        m_n[d]++;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            @(posedge sys_clk);
            #1;
            model_step(0);
            model_step(1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_led_out"}, if_a.led_out, 0);
        check({tag, "_a_period_start"}, if_a.period_start, 0);
        check({tag, "_a_busy"}, if_a.busy, 0);
        check({tag, "_b_led_out"}, if_b.led_out, 0);
        check({tag, "_b_period_start"}, if_b.period_start, 0);
        check({tag, "_b_busy"}, if_b.busy, 0);
    endtask

    // Entered #1 after a posedge; asserts reset between edges and checks
    // that the outputs clear without waiting for a clock.
    task automatic do_reset(input string tag);
        #2;
        sys_nrst = 1'b0;
        #1;
        check_reset_outputs({tag, "_async"});
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_outputs({tag, "_held"});
        sys_nrst = 1'b1;
        model_reset();
        $display("reset %s released", tag);
    endtask

    initial begin
        set_in(8'h00, 8'd0, 1'b1);
        @(posedge sys_clk);
        #1;
        do_reset("init");

        // Short ramp to 4 on channel 0
        set_in(8'h01, 8'd4, 1'b1);
        run(1600);

        // Jump to full brightness, hold, then fade down and finally snap off
        set_in(8'hFF, 8'd255, 1'b0);
        run(5000);
        set_in(8'h00, 8'd255, 1'b1);
        run(3000);
        set_in(8'h00, 8'd255, 1'b0);
        run(3000);

        // Jump to half brightness on channels 0 and 7
        set_in(8'h81, 8'd128, 1'b0);
        run(3000);
        set_in(8'h00, 8'd0, 1'b0);
        run(2100);

        // Ramp channel 0 up, then reverse before the following tick
        set_in(8'h01, 8'd200, 1'b1);
        run(10 * 256 + 100);
        set_in(8'h00, 8'd200, 1'b1);
        run(3000);

        // Long ramp, then reset in the middle of it
        set_in(8'hF1, 8'd100, 1'b1);
        run(50 * 256 + 10);
        do_reset("mid_ramp");
        run(2100);

        // Randomized segments, including cap drops below lit levels
        for (int s = 0; s < 12; s++) begin
            set_in(8'($urandom), 8'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
            run($urandom_range(100, 2500));
        end
        set_in(8'($urandom), 8'($urandom_range(0, 255)), 1'b0);
        run(2100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
